// File: rtl/weight_monitor.sv
// Cabin load tracker: counts passenger enter/exit events into a kg estimate and
// drives overload / door-hold / alarm flags with hysteresis and a persistence timer.
module weight_monitor #(
    parameter int unsigned CNT_W        = 10,
    parameter int unsigned UNIT_W       = 75,
    parameter int unsigned MAX_LOAD     = 600,
    parameter int unsigned HYST         = 75,
    parameter int unsigned ALARM_CYCLES = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enter_sensor,
    input  logic             exit_sensor,
    input  logic             weight_clear,
    output logic [CNT_W-1:0] load,
    output logic             weight_limit_exceeded,
    output logic             door_hold,
    output logic             overload_alarm,
    output logic             underflow_err
);

    localparam int unsigned CLR_LVL = MAX_LOAD - HYST;
    localparam int unsigned AC_W    = (ALARM_CYCLES > 1) ? $clog2(ALARM_CYCLES) : 1;

    typedef enum logic [1:0] {
        ST_NORMAL   = 2'd0,
        ST_OVERLOAD = 2'd1,
        ST_ALARM    = 2'd2
    } state_t;

    logic             r_ent_s1, r_ent_s2, r_ent_prev;
    logic             r_ext_s1, r_ext_s2, r_ext_prev;
    logic [CNT_W-1:0] r_load;
    logic             r_uf;
    state_t           r_state;
    logic [AC_W-1:0]  r_cnt;
    logic             r_wle, r_door, r_alarm;

    logic             w_ent_evt, w_ext_evt;
    logic [CNT_W:0]   w_sum;
    logic [CNT_W-1:0] w_load_nxt;
    logic             w_uf_nxt;
    state_t           w_state_nxt;
    logic [AC_W-1:0]  w_cnt_nxt;
    logic             w_over, w_at_clr;

    // Two-flop synchronisers plus a delay flop for rising-edge detection
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ent_s1   <= 1'b0;
            r_ent_s2   <= 1'b0;
            r_ent_prev <= 1'b0;
            r_ext_s1   <= 1'b0;
            r_ext_s2   <= 1'b0;
            r_ext_prev <= 1'b0;
        end else begin
            r_ent_s1   <= enter_sensor;
            r_ent_s2   <= r_ent_s1;
            r_ent_prev <= r_ent_s2;
            r_ext_s1   <= exit_sensor;
            r_ext_s2   <= r_ext_s1;
            r_ext_prev <= r_ext_s2;
        end
    end

    assign w_ent_evt = r_ent_s2 & ~r_ent_prev;
    assign w_ext_evt = r_ext_s2 & ~r_ext_prev;
    assign w_sum     = {1'b0, r_load} + (CNT_W+1)'(UNIT_W);

    always_comb begin
        w_load_nxt = r_load;
        w_uf_nxt   = r_uf;
        if (weight_clear) begin
            w_load_nxt = '0;
            w_uf_nxt   = 1'b0;
        end else if (w_ent_evt && w_ext_evt) begin
            w_load_nxt = r_load;
        end else if (w_ent_evt) begin
            w_load_nxt = w_sum[CNT_W] ? {CNT_W{1'b1}} : w_sum[CNT_W-1:0];
        end else if (w_ext_evt) begin
            if (r_load >= CNT_W'(UNIT_W)) begin
                w_load_nxt = r_load - CNT_W'(UNIT_W);
            end else begin
                w_load_nxt = '0;
                w_uf_nxt   = 1'b1;
            end
        end
    end

    // FSM looks at the registered load, so flags trail load by one cycle
    assign w_over   = (r_load >  CNT_W'(MAX_LOAD));
    assign w_at_clr = (r_load <= CNT_W'(CLR_LVL));

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        if (weight_clear) begin
            w_state_nxt = ST_NORMAL;
            w_cnt_nxt   = '0;
        end else begin
            case (r_state)
                ST_NORMAL: begin
                    if (w_over) begin
                        w_state_nxt = ST_OVERLOAD;
                        w_cnt_nxt   = '0;
                    end
                end
                ST_OVERLOAD: begin
                    if (w_at_clr) begin
                        w_state_nxt = ST_NORMAL;
                        w_cnt_nxt   = '0;
                    end else if (r_cnt == AC_W'(ALARM_CYCLES - 1)) begin
                        w_state_nxt = ST_ALARM;
                    end else begin
                        w_cnt_nxt = r_cnt + AC_W'(1);
                    end
                end
                ST_ALARM: begin
                    if (w_at_clr) begin
                        w_state_nxt = ST_NORMAL;
                        w_cnt_nxt   = '0;
                    end
                end
                default: begin
                    w_state_nxt = ST_NORMAL;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_load  <= '0;
            r_uf    <= 1'b0;
            r_state <= ST_NORMAL;
            r_cnt   <= '0;
            r_wle   <= 1'b0;
            r_door  <= 1'b0;
            r_alarm <= 1'b0;
        end else begin
            r_load  <= w_load_nxt;
            r_uf    <= w_uf_nxt;
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_wle   <= (w_state_nxt != ST_NORMAL);
            r_door  <= (w_state_nxt != ST_NORMAL);
            r_alarm <= (w_state_nxt == ST_ALARM);
        end
    end

    assign load                  = r_load;
    assign underflow_err         = r_uf;
    assign weight_limit_exceeded = r_wle;
    assign door_hold             = r_door;
    assign overload_alarm        = r_alarm;

endmodule
